// File: rtl/sdram_rw_arbiter_if.sv
// Request/ack bundle between the frame-buffer arbiter and its FIFOs / SDRAM burst engine.
// master = arbiter side, slave = environment (FIFOs + SDRAM top-level).
interface sdram_rw_arbiter_if #(
  parameter int ADDR_W  = 20,
  parameter int FIFO_AW = 10
);
  logic               image_rd_en;
  logic               vga_rd_req;
  logic [FIFO_AW:0]   wr_fifo_used;
  logic [FIFO_AW:0]   rd_fifo_used;
  logic               write_ack;
  logic               read_ack;
  logic               write_en;
  logic               read_en;
  logic [ADDR_W-1:0]  addr;
  logic               frame_done;
  logic               rd_frame_start;

  modport master (
    input  image_rd_en, vga_rd_req, wr_fifo_used, rd_fifo_used, write_ack, read_ack,
    output write_en, read_en, addr, frame_done, rd_frame_start
  );

  modport slave (
    output image_rd_en, vga_rd_req, wr_fifo_used, rd_fifo_used, write_ack, read_ack,
    input  write_en, read_en, addr, frame_done, rd_frame_start
  );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// Round-robin scheduler of write/read bursts onto the shared SDRAM burst engine,
// with ping-pong frame banks selected by the address MSB.
module sdram_rw_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW     = 10
) (
  input logic                 S_CLK,
  input logic                 RST,
  sdram_rw_arbiter_if.master  bus
);

  localparam int PTR_W = ADDR_W - 1;
  localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(BURST_LEN);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [FIFO_AW:0] WR_THRESH = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0] RD_THRESH = (FIFO_AW+1)'((1 << FIFO_AW) - BURST_LEN);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

  state_t           state;
  grant_t           last_grant;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_bank;
  logic             rd_bank;
  logic             done_bank;
  logic             frame_valid;
  logic             frame_ready;

  logic wr_pend;
  logic rd_pend;
  logic go_write;
  logic go_read;

  always_comb begin
    wr_pend  = bus.image_rd_en && (bus.wr_fifo_used >= WR_THRESH);
    rd_pend  = bus.vga_rd_req && frame_valid && (bus.rd_fifo_used <= RD_THRESH);
    go_write = wr_pend && (!rd_pend || last_grant == GRANT_READ);
    go_read  = rd_pend && (!wr_pend || last_grant == GRANT_WRITE);
  end

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state              <= IDLE;
      last_grant         <= GRANT_READ;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      wr_bank            <= 1'b0;
      rd_bank            <= 1'b0;
      done_bank          <= 1'b0;
      frame_valid        <= 1'b0;
      frame_ready        <= 1'b0;
      bus.write_en       <= 1'b0;
      bus.read_en        <= 1'b0;
      bus.addr           <= '0;
      bus.frame_done     <= 1'b0;
      bus.rd_frame_start <= 1'b0;
    end else begin
      bus.frame_done     <= 1'b0;
      bus.rd_frame_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go_write) begin
            state        <= WRITE;
            last_grant   <= GRANT_WRITE;
            bus.write_en <= 1'b1;
            bus.addr     <= {wr_bank, wr_ptr};
          end else if (go_read) begin
            state              <= READ;
            last_grant         <= GRANT_READ;
            bus.read_en        <= 1'b1;
            bus.addr           <= {rd_bank, rd_ptr};
            bus.rd_frame_start <= (rd_ptr == '0);
          end
        end
        WRITE: begin
          if (bus.write_ack) begin
            state        <= IDLE;
            bus.write_en <= 1'b0;
            if (wr_ptr == PTR_LAST) begin
              // Frame complete: publish this bank to the reader, start filling the other.
              wr_ptr         <= '0;
              done_bank      <= wr_bank;
              wr_bank        <= ~wr_bank;
              frame_valid    <= 1'b1;
              frame_ready    <= 1'b1;
              bus.frame_done <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PTR_STEP;
            end
          end
        end
        READ: begin
          if (bus.read_ack) begin
            state       <= IDLE;
            bus.read_en <= 1'b0;
            if (rd_ptr == PTR_LAST) begin
              // Switch to the newest finished frame if one exists, else repeat this one.
              rd_ptr <= '0;
              if (frame_ready) begin
                rd_bank     <= done_bank;
                frame_ready <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + PTR_STEP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
